pc_control_unit: RTL and testbench

- Program-counter stage directly upstream of the instruction fetch stage.
- Holds the architectural PC (a word address driven into the instruction ROM) and selects the next PC: sequential, PC-relative branch, absolute jump, or call-with-link.
- Handles pipeline stall, halt/resume, and a post-redirect flush pulse that tells downstream stages to squash the wrong-path instruction.

---
 rtl/pc_control_unit.sv | 120 ++++++++++++
 tb/tb_pc_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control_unit.sv
// Program-counter stage feeding instruction fetch: next-PC selection, stall/halt handling, call link and flush pulse.
// Optional build macro PC_BRANCH_STATS_EN adds saturating taken/flush counters.
module pc_control_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_take,
    input  logic [31:0] branch_offset,
    input  logic        jump_en,
    input  logic        call_en,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] PC,
    output logic [31:0] next_pc,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic        flush,
    output logic        halted
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0] taken_count,
    output logic [15:0] flush_count
`endif
);

    localparam logic [31:0] ADDR_MASK =
        (ADDR_BITS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_BITS) - 32'd1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] seq_pc;
    logic        redirect;
    logic        do_call;

    assign seq_pc = (PC + 32'd1) & ADDR_MASK;
    assign halted = (state == S_HALT);

    always_comb begin
        next_state = state;
        next_pc    = PC;
        redirect   = 1'b0;
        do_call    = 1'b0;
        case (state)
            S_BOOT: begin
                // PC stays on RESET_PC so the ROM's first read completes.
                next_state = S_RUN;
            end
            S_RUN: begin
                if (stall) begin
                    next_pc = PC;
                end else if (halt_req) begin
                    next_state = S_HALT;
                end else if (jump_en) begin
                    next_pc  = jump_target & ADDR_MASK;
                    redirect = 1'b1;
                    do_call  = call_en;
                end else if (branch_take) begin
                    next_pc  = (PC + branch_offset) & ADDR_MASK;
                    redirect = 1'b1;
                end else begin
                    next_pc = seq_pc;
                end
            end
            S_HALT: begin
                if (resume) begin
                    next_state = S_RUN;
                    next_pc    = seq_pc;
                end
            end
            default: begin
                next_state = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_BOOT;
            PC        <= RESET_PC & ADDR_MASK;
            link_addr <= '0;
            link_we   <= 1'b0;
            flush     <= 1'b0;
        end else begin
            state   <= next_state;
            PC      <= next_pc;
            flush   <= redirect;
            link_we <= do_call;
            if (do_call) begin
                link_addr <= seq_pc;
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_count <= '0;
            flush_count <= '0;
        end else begin
            if (redirect && (taken_count != '1)) begin
                taken_count <= taken_count + 16'd1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: expected outputs are queued as stimulus is driven and checked after each edge.
module tb_pc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_take;
    logic [31:0] branch_offset;
    logic        jump_en;
    logic        call_en;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] PC;
    logic [31:0] next_pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic        flush;
    logic        halted;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_count;
    logic [15:0] flush_count;
`endif

    pc_control_unit #(
        .RESET_PC (32'd0),
        .ADDR_BITS(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_take  (branch_take),
        .branch_offset(branch_offset),
        .jump_en      (jump_en),
        .call_en      (call_en),
        .jump_target  (jump_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .PC           (PC),
        .next_pc      (next_pc),
        .link_addr    (link_addr),
        .link_we      (link_we),
        .flush        (flush),
        .halted       (halted)
`ifdef PC_BRANCH_STATS_EN
        ,
        .taken_count  (taken_count),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        fl;
        logic        lw;
        logic        h;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic obs_t sample();
        sample = {PC, flush, link_we, halted};
    endfunction

    task automatic push(input logic [31:0] pc, input logic fl, input logic lw, input logic h,
                        input string tag);
        exp_t e;
        e.v   = {pc, fl, lw, h};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive_idle();
        stall         = 1'b0;
        branch_take   = 1'b0;
        branch_offset = '0;
        jump_en       = 1'b0;
        call_en       = 1'b0;
        jump_target   = '0;
        halt_req      = 1'b0;
        resume        = 1'b0;
    endtask

    // Fields printed as one packed value {pc, flush, link_we, halted}.
    task automatic test_reset();
        exp_t e;
        obs_t got;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        push(32'd0, 1'b0, 1'b0, 1'b0, "in_reset");
        e = sb.pop_front(); got = sample(); vectors++;
        if (got !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
        end
        vectors++;
        if (link_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_link_addr: got %h expected %h", link_addr, 32'd0);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (next_pc !== 32'd0) begin
            miscompares++;
            $display("FAIL boot_next_pc: got %h expected %h", next_pc, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            push((i == 0) ? 32'd0 : i, 1'b0, 1'b0, 1'b0, $sformatf("boot_seq_%0d", i));
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        obs_t got;
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            case (i)
                0: begin jump_en = 1'b1; jump_target = 32'd8;
                         push(32'd8, 1'b1, 1'b0, 1'b0, "jump_to_8"); end
                1: begin branch_take = 1'b1; branch_offset = 32'hFFFF_FFFD;
                         push(32'd5, 1'b1, 1'b0, 1'b0, "branch_minus3"); end
                default: push(32'd6, 1'b0, 1'b0, 1'b0, "after_branch");
            endcase
            #1;
            if (i == 1) begin
                vectors++;
                if (next_pc !== 32'd5) begin
                    miscompares++;
                    $display("FAIL branch_next_pc: got %h expected %h", next_pc, 32'd5);
                end
            end
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_call_stall();
        exp_t e;
        obs_t got;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            case (i)
                0: begin jump_en = 1'b1; jump_target = 32'd4;
                         push(32'd4, 1'b1, 1'b0, 1'b0, "jump_to_4"); end
                1, 2: begin stall = 1'b1; jump_en = 1'b1; call_en = 1'b1; jump_target = 32'h40;
                         push(32'd4, 1'b0, 1'b0, 1'b0, "call_stalled"); end
                3: begin jump_en = 1'b1; call_en = 1'b1; jump_target = 32'h40;
                         push(32'h40, 1'b1, 1'b1, 1'b0, "call_taken"); end
                default: push(32'h41, 1'b0, 1'b0, 1'b0, "after_call");
            endcase
            #1;
            if (i == 1 || i == 2) begin
                vectors++;
                if (next_pc !== 32'd4) begin
                    miscompares++;
                    $display("FAIL stall_next_pc: got %h expected %h", next_pc, 32'd4);
                end
            end
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
            if (i >= 3) begin
                vectors++;
                if (link_addr !== 32'd5) begin
                    miscompares++;
                    $display("FAIL call_link_addr: got %h expected %h", link_addr, 32'd5);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        obs_t got;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            case (i)
                0: begin jump_en = 1'b1; jump_target = 32'd1023;
                         push(32'd1023, 1'b1, 1'b0, 1'b0, "jump_to_1023"); end
                1: begin call_en = 1'b1;
                         push(32'd0, 1'b0, 1'b0, 1'b0, "seq_wrap_to_0"); end
                2: begin jump_en = 1'b1; jump_target = 32'hFFFF_FC10;
                         push(32'h10, 1'b1, 1'b0, 1'b0, "jump_upper_masked"); end
                3: begin branch_take = 1'b1; branch_offset = 32'hFFFF_FFE0;
                         push(32'h3F0, 1'b1, 1'b0, 1'b0, "branch_neg_wrap"); end
                default: push(32'h3F1, 1'b0, 1'b0, 1'b0, "after_wrap");
            endcase
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
            if (i == 1) begin
                vectors++;
                if (link_addr !== 32'd5) begin
                    miscompares++;
                    $display("FAIL lone_call_en_link: got %h expected %h", link_addr, 32'd5);
                end
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        obs_t got;
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            case (i)
                0: begin jump_en = 1'b1; jump_target = 32'h20;
                         push(32'h20, 1'b1, 1'b0, 1'b0, "jump_to_20"); end
                1: begin halt_req = 1'b1; jump_en = 1'b1; jump_target = 32'h100;
                         push(32'h20, 1'b0, 1'b0, 1'b1, "halt_enter"); end
                2, 3, 4, 5: begin branch_take = 1'b1; branch_offset = 32'd5; stall = i[0];
                         push(32'h20, 1'b0, 1'b0, 1'b1, "halt_hold"); end
                6: begin resume = 1'b1; stall = 1'b1;
                         push(32'h21, 1'b0, 1'b0, 1'b0, "resume"); end
                default: push(32'h22, 1'b0, 1'b0, 1'b0, "after_resume");
            endcase
            #1;
            if (i >= 2 && i <= 6) begin
                vectors++;
                if (next_pc !== ((i == 6) ? 32'h21 : 32'h20)) begin
                    miscompares++;
                    $display("FAIL halt_next_pc: got %h expected %h", next_pc,
                             (i == 6) ? 32'h21 : 32'h20);
                end
            end
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_reset_midflush();
        exp_t e;
        obs_t got;
        drive_idle();
        jump_en = 1'b1; call_en = 1'b1; jump_target = 32'h30;
        push(32'h30, 1'b1, 1'b1, 1'b0, "call_before_reset");
        @(posedge clk); #1;
        e = sb.pop_front(); got = sample(); vectors++;
        if (got !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
        end
        drive_idle();
        #3;
        reset = 1'b1;
        push(32'd0, 1'b0, 1'b0, 1'b0, "async_reset");
        #1;
        e = sb.pop_front(); got = sample(); vectors++;
        if (got !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
        end
        vectors++;
        if (link_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset_link: got %h expected %h", link_addr, 32'd0);
        end
        #2;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(i, 1'b0, 1'b0, 1'b0, (i == 0) ? "reboot_hold" : "reboot_seq");
            @(posedge clk); #1;
            e = sb.pop_front(); got = sample(); vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_branch();
        test_call_stall();
        test_wrap();
        test_halt();
        test_reset_midflush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
